// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: PC width, FSM states, queued prediction entry.
package branch_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
  } entry_t;

endpackage

// File: rtl/branch_fifo.sv
// In-flight prediction FIFO.
// Ports: clk_i/reset_ni clock and async active-low reset; push/wr_data enqueue at tail;
// pop dequeues head (rd_data shows head); clear empties the queue and wins over push/pop;
// full/empty/count report fill level.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  entry_t                   wr_data,
  output entry_t                   rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: queues predictions, compares each against the resolved branch in
// order, trains the predictor, and flushes the pipeline on a mispredict.
// Ports: clk_i/reset_ni; pred_* prediction input with pred_ready_o (combinational);
// res_* resolution of the oldest branch; upd_* registered training update;
// mispredict_o/flush_o/orphan_o registered pulses; hit/miss saturating counters;
// occupancy_o number of queued predictions.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   pred_valid_i,
  input  logic                   pred_taken_i,
  input  logic [PC_W-1:0]        pred_pc_i,
  output logic                   pred_ready_o,
  input  logic                   res_valid_i,
  input  logic                   res_taken_i,
  input  logic [PC_W-1:0]        res_target_i,
  output logic                   upd_valid_o,
  output logic                   upd_taken_o,
  output logic [PC_W-1:0]        upd_pc_o,
  output logic                   mispredict_o,
  output logic                   flush_o,
  output logic                   orphan_o,
  output logic [CNT_W-1:0]       hit_count_o,
  output logic [CNT_W-1:0]       miss_count_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  state_e  state_q;
  state_e  state_d;
  entry_t  head;
  entry_t  wr_entry;
  logic    fifo_full;
  logic    fifo_empty;
  logic    push_c;
  logic    resolve_c;
  logic    mispredict_c;
  logic    pop_c;
  logic    clear_c;

  logic             upd_valid_q;
  logic             upd_taken_q;
  logic [PC_W-1:0]  upd_pc_q;
  logic             mispredict_q;
  logic             flush_q;
  logic             orphan_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  assign wr_entry = '{taken: pred_taken_i, pc: pred_pc_i};

  branch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push     (push_c),
    .pop      (pop_c),
    .clear    (clear_c),
    .wr_data  (wr_entry),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy_o)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= RUN;
    else           state_q <= state_d;
  end

  // Next state plus handshake/resolve decode. The PC only matters when both
  // directions say taken; a not-taken branch has no meaningful target.
  always_comb begin
    state_d      = state_q;
    pred_ready_o = 1'b0;
    resolve_c    = 1'b0;
    mispredict_c = 1'b0;
    case (state_q)
      RUN: begin
        pred_ready_o = !fifo_full;
        resolve_c    = res_valid_i && !fifo_empty;
        mispredict_c = resolve_c &&
                       ((head.taken != res_taken_i) ||
                        (head.taken && res_taken_i && (head.pc != res_target_i)));
        if (mispredict_c) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A mispredict clears the queue, which also drops any same-cycle push.
  assign push_c  = pred_valid_i && pred_ready_o;
  assign pop_c   = resolve_c && !mispredict_c;
  assign clear_c = mispredict_c;

  // Registered update, pulses and statistics.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      upd_valid_q  <= 1'b0;
      upd_taken_q  <= 1'b0;
      upd_pc_q     <= '0;
      mispredict_q <= 1'b0;
      flush_q      <= 1'b0;
      orphan_q     <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      upd_valid_q  <= resolve_c;
      mispredict_q <= mispredict_c;
      flush_q      <= (state_d == FLUSH);
      orphan_q     <= res_valid_i && !resolve_c;
      if (resolve_c) begin
        upd_taken_q <= res_taken_i;
        upd_pc_q    <= res_target_i;
        if (mispredict_c) begin
          if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        end else begin
          if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
        end
      end
    end
  end

  assign upd_valid_o  = upd_valid_q;
  assign upd_taken_o  = upd_taken_q;
  assign upd_pc_o     = upd_pc_q;
  assign mispredict_o = mispredict_q;
  assign flush_o      = flush_q;
  assign orphan_o     = orphan_q;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios with literal expectations
// plus a randomized phase, all outputs checked every cycle against a queue-based model.
module tb_branch_resolver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
  } pred_t;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          pred_valid_i = 1'b0;
  logic          pred_taken_i = 1'b0;
  logic [31:0]   pred_pc_i = '0;
  logic          pred_ready_o;
  logic          res_valid_i = 1'b0;
  logic          res_taken_i = 1'b0;
  logic [31:0]   res_target_i = '0;
  logic          upd_valid_o;
  logic          upd_taken_o;
  logic [31:0]   upd_pc_o;
  logic          mispredict_o;
  logic          flush_o;
  logic          orphan_o;
  logic [CW-1:0] hit_count_o;
  logic [CW-1:0] miss_count_o;
  logic [OW-1:0] occupancy_o;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  branch_resolver #(
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .pred_valid_i (pred_valid_i),
    .pred_taken_i (pred_taken_i),
    .pred_pc_i    (pred_pc_i),
    .pred_ready_o (pred_ready_o),
    .res_valid_i  (res_valid_i),
    .res_taken_i  (res_taken_i),
    .res_target_i (res_target_i),
    .upd_valid_o  (upd_valid_o),
    .upd_taken_o  (upd_taken_o),
    .upd_pc_o     (upd_pc_o),
    .mispredict_o (mispredict_o),
    .flush_o      (flush_o),
    .orphan_o     (orphan_o),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o),
    .occupancy_o  (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  pred_t       mq[$];
  bit          m_in_flush;
  bit          e_upd_valid, e_upd_taken, e_mis, e_flush, e_orphan;
  logic [31:0] e_upd_pc;
  int unsigned e_hit, e_miss;
  int unsigned cnt_max = (1 << CW) - 1;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mq.delete();
      m_in_flush  = 0;
      e_upd_valid = 0; e_upd_taken = 0; e_upd_pc = '0;
      e_mis = 0; e_flush = 0; e_orphan = 0;
      e_hit = 0; e_miss = 0;
    end else begin
      bit    accept, resolve, wrong;
      pred_t head;
      pred_t np;
      accept  = pred_valid_i && !m_in_flush && (mq.size() < DEPTH);
      resolve = res_valid_i && !m_in_flush && (mq.size() > 0);
      wrong   = 0;
      if (resolve) begin
        head  = mq[0];
        wrong = (head.taken != res_taken_i) ||
                (head.taken && res_taken_i && head.pc != res_target_i);
        e_upd_taken = res_taken_i;
        e_upd_pc    = res_target_i;
        if (wrong) begin
          mq.delete();
          if (e_miss < cnt_max) e_miss++;
        end else begin
          void'(mq.pop_front());
          if (e_hit < cnt_max) e_hit++;
        end
      end
      if (accept && !wrong) begin
        np.taken = pred_taken_i;
        np.pc    = pred_pc_i;
        mq.push_back(np);
      end
      e_upd_valid = resolve;
      e_mis       = wrong;
      e_flush     = wrong;
      e_orphan    = res_valid_i && !resolve;
      m_in_flush  = wrong;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle out of reset, mid-cycle.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      chk("pred_ready", 32'(pred_ready_o), 32'(!m_in_flush && mq.size() < DEPTH));
      chk("upd_valid",  32'(upd_valid_o),  32'(e_upd_valid));
      chk("upd_taken",  32'(upd_taken_o),  32'(e_upd_taken));
      chk("upd_pc",     upd_pc_o,          e_upd_pc);
      chk("mispredict", 32'(mispredict_o), 32'(e_mis));
      chk("flush",      32'(flush_o),      32'(e_flush));
      chk("orphan",     32'(orphan_o),     32'(e_orphan));
      chk("hit_count",  32'(hit_count_o),  e_hit);
      chk("miss_count", 32'(miss_count_o), e_miss);
      chk("occupancy",  32'(occupancy_o),  32'(mq.size()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic pv, input logic pt, input logic [31:0] ppc,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    @(negedge clk_i);
    pred_valid_i = pv; pred_taken_i = pt; pred_pc_i = ppc;
    res_valid_i  = rv; res_taken_i  = rt; res_target_i = rtg;
  endtask

  task automatic settle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_occ",  32'(occupancy_o), 0);
    chk("rst_upc",  upd_pc_o, 0);
    chk("rst_flush", 32'(flush_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("rst_ready", 32'(pred_ready_o), 1);

    // Correct taken prediction.
    drive(1, 1, 32'h100, 0, 0, '0);
    drive(0, 0, '0, 1, 1, 32'h100);
    settle();
    chk("t1_upd_valid", 32'(upd_valid_o), 1);
    chk("t1_upd_pc",    upd_pc_o, 32'h100);
    chk("t1_mis",       32'(mispredict_o), 0);
    chk("t1_hit",       32'(hit_count_o), 1);

    // Wrong target: mispredict, flush, queue emptied.
    drive(1, 1, 32'h100, 0, 0, '0);
    drive(1, 1, 32'h200, 0, 0, '0);
    drive(1, 1, 32'h300, 0, 0, '0);
    drive(0, 0, '0, 1, 1, 32'h104);
    settle();
    chk("t2_mis",   32'(mispredict_o), 1);
    chk("t2_flush", 32'(flush_o), 1);
    chk("t2_ready", 32'(pred_ready_o), 0);
    chk("t2_occ",   32'(occupancy_o), 0);
    chk("t2_miss",  32'(miss_count_o), 1);
    idle();
    settle();
    chk("t2_flush_end", 32'(flush_o), 0);
    chk("t2_ready_end", 32'(pred_ready_o), 1);

    // Full queue; push alongside a pop is still rejected.
    for (int i = 1; i <= 4; i++) drive(1, 1, 32'(i * 16), 0, 0, '0);
    settle();
    chk("t3_ready_full", 32'(pred_ready_o), 0);
    chk("t3_occ_full",   32'(occupancy_o), 4);
    drive(1, 1, 32'h50, 1, 1, 32'h10);
    settle();
    chk("t3_occ", 32'(occupancy_o), 3);
    chk("t3_hit", 32'(hit_count_o), 2);
    for (int i = 2; i <= 4; i++) drive(0, 0, '0, 1, 1, 32'(i * 16));
    settle();
    chk("t3_hit_after", 32'(hit_count_o), 5);
    chk("t3_occ_empty", 32'(occupancy_o), 0);

    // Orphan resolve.
    drive(0, 0, '0, 1, 1, 32'h999);
    settle();
    chk("t4_orphan", 32'(orphan_o), 1);
    chk("t4_updv",   32'(upd_valid_o), 0);
    chk("t4_hit",    32'(hit_count_o), 5);
    chk("t4_miss",   32'(miss_count_o), 1);
    idle();
    settle();
    chk("t4_orphan_end", 32'(orphan_o), 0);

    // Not-taken: PC ignored; direction mismatch mispredicts.
    drive(1, 0, 32'hDEAD, 0, 0, '0);
    drive(0, 0, '0, 1, 0, 32'h0);
    settle();
    chk("t5_mis",   32'(mispredict_o), 0);
    chk("t5_hit",   32'(hit_count_o), 6);
    chk("t5_utk",   32'(upd_taken_o), 0);
    chk("t5_upc",   upd_pc_o, 0);
    drive(1, 1, 32'h1000, 0, 0, '0);
    drive(0, 0, '0, 1, 0, 32'h1000);
    settle();
    chk("t5_dir_mis", 32'(mispredict_o), 1);
    chk("t5_miss",    32'(miss_count_o), 2);
    idle();

    // Hit counter saturation.
    for (int i = 0; i < 30; i++) begin
      drive(1, 1, 32'(i), 0, 0, '0);
      drive(0, 0, '0, 1, 1, 32'(i));
    end
    settle();
    chk("t6_sat", 32'(hit_count_o), 32'h1F);
    idle();
    drive(0, 0, '0, 1, 0, 32'h0);
    settle();
    chk("t6_orphan_nohit", 32'(hit_count_o), 32'h1F);
    drive(1, 1, 32'h44, 0, 0, '0);
    drive(0, 0, '0, 1, 1, 32'h44);
    settle();
    chk("t6_sat_hold", 32'(hit_count_o), 32'h1F);
    chk("t6_updv",     32'(upd_valid_o), 1);

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h7000 + 32'(i), 0, 0, '0);
    idle();
    @(negedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t7_async_occ", 32'(occupancy_o), 0);
    chk("t7_async_hit", 32'(hit_count_o), 0);
    res_valid_i = 1'b1; res_taken_i = 1'b1; res_target_i = 32'h7000;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    settle();
    chk("t7_orphan", 32'(orphan_o), 1);
    chk("t7_updv",   32'(upd_valid_o), 0);
    chk("t7_hit",    32'(hit_count_o), 0);
    idle();

    // Randomized traffic; resolves usually match the model's head to keep hits common.
    for (int n = 0; n < 3000; n++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] ppc, rtg;
      pv  = ($urandom_range(0, 9) < 6);
      pt  = 1'($urandom);
      ppc = 32'($urandom_range(0, 7)) << 2;
      rv  = ($urandom_range(0, 9) < 5);
      rt  = 1'($urandom);
      rtg = 32'($urandom_range(0, 7)) << 2;
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        rt = mq[0].taken;
        if (mq[0].taken) rtg = mq[0].pc;
      end
      drive(pv, pt, ppc, rv, rt, rtg);
      if (n == 1500) begin
        @(negedge clk_i);
        #3;
        reset_ni = 1'b0;
        #2;
        chk("rand_async_occ", 32'(occupancy_o), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
      end
    end
    idle();
    repeat (3) @(posedge clk_i);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4, is the number of in-flight predictions held; it SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 16, is the width of the hit and miss counters.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 Port pred_valid_i, input, 1 bit: the predictor presents a prediction this cycle.
REQ-006 Port pred_taken_i, input, 1 bit: predicted direction (1 = taken).
REQ-007 Port pred_pc_i, input, 32 bits: predicted target PC.
REQ-008 Port pred_ready_o, output, 1 bit: a prediction can be accepted this cycle.
REQ-009 Port res_valid_i, input, 1 bit: the oldest outstanding branch resolves this cycle.
REQ-010 Port res_taken_i, input, 1 bit: actual branch direction.
REQ-011 Port res_target_i, input, 32 bits: actual jump target.
REQ-012 Port upd_valid_o, input-facing output, 1 bit: pulse to the predictor carrying the training update.
REQ-013 Port upd_taken_o, output, 1 bit: update direction, driven to the predictor's branch_result.
REQ-014 Port upd_pc_o, output, 32 bits: update target, driven to the predictor's next_PC.
REQ-015 Port mispredict_o, output, 1 bit: misprediction pulse.
REQ-016 Port flush_o, output, 1 bit: pipeline flush pulse.
REQ-017 Port orphan_o, output, 1 bit: pulse for a resolution that arrives with no outstanding prediction.
REQ-018 Ports hit_count_o and miss_count_o, outputs, CNT_W bits each: prediction statistics.
REQ-019 Port occupancy_o, output, clog2(DEPTH)+1 bits: the number of queued predictions.

Function
REQ-020 Predictions SHALL be stored in FIFO order as {taken, pc} entries.
REQ-021 A push SHALL occur only when pred_valid_i and pred_ready_o are both high.
REQ-022 pred_ready_o SHALL be combinational: high only when state is RUN and occupancy is below DEPTH; a pop in the same cycle does not free space for a push.
REQ-023 A resolve SHALL occur when res_valid_i is high, state is RUN and occupancy is above 0; it pops the head entry.
REQ-024 A resolve SHALL be a mispredict when head.taken differs from res_taken_i, or when both are 1 and head.pc differs from res_target_i.
REQ-025 When both are 0, the PC SHALL NOT be compared.
REQ-026 On the cycle after a resolve, the block SHALL drive upd_valid_o=1, upd_taken_o=res_taken_i and upd_pc_o=res_target_i, all registered with 1-cycle latency.
REQ-027 On the cycle after a resolve, mispredict_o SHALL equal the comparison result.
REQ-028 upd_taken_o and upd_pc_o SHALL hold their values between updates.
REQ-029 A non-mispredict resolve SHALL increment hit_count_o; a mispredict SHALL increment miss_count_o.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 State machine states are RUN and FLUSH.
REQ-032 In RUN, a mispredict SHALL empty the FIFO (all younger entries discarded), drop any same-cycle push, and move to FLUSH.
REQ-033 FLUSH SHALL last exactly 1 cycle, with flush_o=1 and pred_ready_o=0, and SHALL then return to RUN.
REQ-034 A res_valid_i that is high while occupancy is 0 or state is FLUSH SHALL be ignored, except for a registered 1-cycle orphan_o pulse; counters and upd_valid_o SHALL be unaffected.
REQ-035 A simultaneous push and non-mispredict pop SHALL leave occupancy unchanged, with the new entry placed at the tail.
REQ-036 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-037 While reset_ni is low: FIFO empty, state RUN, all pulse outputs 0, upd_taken_o=0, upd_pc_o=0, counters 0, occupancy_o=0.
REQ-038 No push or resolve SHALL occur while reset_ni is low.
REQ-039 A reset asserted mid-operation SHALL discard all in-flight entries immediately and suppress any pending pulse.

Structure
REQ-040 Shared package branch_pkg SHALL hold PC_W=32, the state enum {RUN, FLUSH} and the entry struct {taken, pc}.
REQ-041 The FIFO SHALL be a sub-module branch_fifo with push, pop, clear, full, empty and count signals.

Verification
REQ-042 Push taken/0x100, then resolve taken/0x100 -> next cycle upd_valid_o=1, upd_pc_o=0x100, mispredict_o=0, hit_count_o=1.
REQ-043 Push taken/0x100, taken/0x200, taken/0x300, then resolve taken/0x104 -> mispredict_o=1, then flush_o=1 for one cycle, occupancy_o=0, miss_count_o=1, pred_ready_o=0 during FLUSH.
REQ-044 Push 4 entries (DEPTH=4) -> pred_ready_o=0; push+resolve in the same cycle -> push rejected, occupancy_o=3.
REQ-045 res_valid_i while empty -> orphan_o=1 for one cycle, no upd_valid_o, counters unchanged.
REQ-046 Push not-taken/0xDEAD, resolve not-taken/0x0 -> hit; preload hit_count_o at all-ones by forcing, then hit -> stays all-ones.
REQ-047 Assert reset_ni low with 3 entries queued -> occupancy_o=0 asynchronously; after release, the first resolve produces orphan_o.
